seven_segment_scan_decoder: RTL and testbench
=============================================

SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digit positions.
REQ-002 Parameter STABLE_CNT, default 3, legal range 1..7: consecutive identical samples required to accept a pattern.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_in  input  1: sole clock; all state changes on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 sample_en  input  1: sample tick; seg_in/dig_sel are considered only on cycles where it is 1.
REQ-007 dig_sel  input  DIGITS: digit strobe, active-high, bit d selects digit d.
REQ-008 seg_in  input  7: segment levels, bit order gfedcba, active-high (bit0 = a).
REQ-009 hex_out  output  4*DIGITS: decoded nibble per digit, digit d in bits [4d+3:4d].
REQ-010 valid  output  DIGITS: 1 = digit d holds a decoded hex value.
REQ-011 pattern_err  output  DIGITS: 1 = last accepted pattern of digit d is not a legal code.
REQ-012 update  output  1: one-cycle pulse, an accepted pattern was committed.
REQ-013 upd_digit  output  clog2(DIGITS): index of the committed digit, meaningful while update = 1.
REQ-014 sel_err  output  1: sticky flag, a sample with non-one-hot dig_sel occurred.

Function
REQ-015 A sample SHALL be taken on a rising edge where sample_en = 1 and dig_sel is exactly one-hot; the selected digit is d.
REQ-016 Samples with dig_sel all-zero SHALL be ignored without state change; multi-hot samples SHALL be ignored and set sel_err.
REQ-017 Per digit: a last_pat register (7 bits) and a run counter (3 bits, saturating at STABLE_CNT) SHALL be kept.
REQ-018 Sample with seg_in != last_pat[d]: last_pat[d] <= seg_in, run[d] <= 1.
REQ-019 Sample with seg_in == last_pat[d] and run[d] < STABLE_CNT: run[d] increments; at STABLE_CNT it saturates.
REQ-020 Commit SHALL occur on the sample where run[d] becomes STABLE_CNT (for STABLE_CNT = 1, every sample with a changed pattern); no re-commit while the run continues.
REQ-021 Commit results SHALL be registered on the same rising edge as the committing sample; visible in the following cycle (latency 1 clock from the STABLE_CNT-th sample).
REQ-022 Legal codes (hex value: pattern): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-023 Commit of a legal code: nibble d <= value, valid[d] <= 1, pattern_err[d] <= 0.
REQ-024 Commit of 7'h00 (blank): valid[d] <= 0, pattern_err[d] <= 0, nibble d held.
REQ-025 Commit of any other pattern: valid[d] <= 0, pattern_err[d] <= 1, nibble d held.
REQ-026 Every commit SHALL assert update for exactly one cycle with upd_digit = d; at most one commit per cycle.
REQ-027 Other digits' state SHALL be unaffected by a sample of digit d.
REQ-028 sample_en on consecutive cycles SHALL be handled at full rate.

Reset
REQ-029 reset = 1 at a rising edge SHALL clear hex_out, valid, pattern_err, update, upd_digit, sel_err, all run counters to 0 and all last_pat to 7'h00; reset takes priority over any concurrent sample.
REQ-030 Reset mid-run SHALL discard partial runs; a subsequent pattern requires STABLE_CNT fresh samples.
REQ-031 After reset, a run of 7'h00 SHALL commit as blank (update pulses, valid stays 0).

Verification
REQ-032 STABLE_CNT=3, dig_sel=0001, seg_in=7'h5B on 3 sample ticks -> after 3rd tick hex_out[3:0]=2, valid=0001, update 1 cycle, upd_digit=0; 4th identical tick -> no update.
REQ-033 Digit 1: seg_in 7'h06,7'h06,7'h4F,7'h4F,7'h4F -> single commit, hex_out[7:4]=3, never 1.
REQ-034 Digit 2 legal 7'h77 committed (A), then 3 samples of 7'h12 -> pattern_err=0100, valid[2]=0, hex_out[11:8] still A.
REQ-035 dig_sel=0110 with sample_en=1 -> sel_err=1, no run/output change; dig_sel=0000 -> no effect, sel_err unchanged.
REQ-036 Digit 3 with two 7'h7F samples, reset asserted, then one 7'h7F sample -> no commit; two more -> commit hex_out[15:12]=8.
REQ-037 Round-robin dig_sel 0001/0010/0100/1000 each tick, seg_in 3F/06/5B/4F, 12 ticks -> hex_out=16'h3210, valid=1111, exactly 4 update pulses.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
// Recovers hex digits from a scanned 7-segment bus; a pattern is accepted after STABLE_CNT identical samples.
// Commit results appear 1 clk after the accepting sample; no backpressure, one sample accepted per cycle.
module seven_segment_scan_decoder #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CNT = 3,
   localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  sample_en,
   input  logic [DIGITS-1:0]     dig_sel,
   input  logic [6:0]            seg_in,
   output logic [4*DIGITS-1:0]   hex_out,
   output logic [DIGITS-1:0]     valid,
   output logic [DIGITS-1:0]     pattern_err,
   output logic                  update,
   output logic [IDX_W-1:0]      upd_digit,
   output logic                  sel_err
);

   localparam logic [2:0] RUN_MAX = 3'(STABLE_CNT);
   localparam logic [2:0] RUN_PRE = 3'(STABLE_CNT - 1);

   logic [6:0]       last_pat [DIGITS];
   logic [2:0]       run_cnt  [DIGITS];

   logic             one_hot;
   logic             take;
   logic             multi_hot;
   logic [IDX_W-1:0] sel_idx;
   logic             same_pat;
   logic [2:0]       next_run;
   logic             commit_now;
   logic [4:0]       dec;

   // Returns {legal, value}; blank and garbage both decode to 5'h00.
   function automatic logic [4:0] decode_seg(input logic [6:0] pat);
      logic [4:0] r;
      r = 5'h00;
      case (pat)
         7'h3F: r = 5'h10;
         7'h06: r = 5'h11;
         7'h5B: r = 5'h12;
         7'h4F: r = 5'h13;
         7'h66: r = 5'h14;
         7'h6D: r = 5'h15;
         7'h7D: r = 5'h16;
         7'h07: r = 5'h17;
         7'h7F: r = 5'h18;
         7'h6F: r = 5'h19;
         7'h77: r = 5'h1A;
         7'h7C: r = 5'h1B;
         7'h39: r = 5'h1C;
         7'h5E: r = 5'h1D;
         7'h79: r = 5'h1E;
         7'h71: r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   always_comb begin
      one_hot   = (|dig_sel) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
      take      = sample_en && one_hot;
      multi_hot = sample_en && (|dig_sel) && !one_hot;
      sel_idx   = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (dig_sel[d]) sel_idx = IDX_W'(d);
      end
      same_pat = (seg_in == last_pat[sel_idx]);
      if (!same_pat)
         next_run = 3'd1;
      else if (run_cnt[sel_idx] < RUN_MAX)
         next_run = run_cnt[sel_idx] + 3'd1;
      else
         next_run = run_cnt[sel_idx];
      // A changed pattern only commits immediately when a single sample suffices.
      commit_now = take && (same_pat ? (run_cnt[sel_idx] == RUN_PRE) : (STABLE_CNT == 1));
      dec        = decode_seg(seg_in);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         hex_out     <= '0;
         valid       <= '0;
         pattern_err <= '0;
         update      <= 1'b0;
         upd_digit   <= '0;
         sel_err     <= 1'b0;
         for (int d = 0; d < DIGITS; d++) begin
            last_pat[d] <= 7'h00;
            run_cnt[d]  <= 3'd0;
         end
      end else begin
         update <= commit_now;
         if (multi_hot) sel_err <= 1'b1;
         if (take) begin
            last_pat[sel_idx] <= seg_in;
            run_cnt[sel_idx]  <= next_run;
         end
         if (commit_now) begin
            upd_digit <= sel_idx;
            if (dec[4]) begin
               hex_out[{sel_idx, 2'b00} +: 4] <= dec[3:0];
               valid[sel_idx]                 <= 1'b1;
               pattern_err[sel_idx]           <= 1'b0;
            end else begin
               valid[sel_idx]       <= 1'b0;
               pattern_err[sel_idx] <= (seg_in != 7'h00);
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder at default parameters (DIGITS=4, STABLE_CNT=3).
module tb_seven_segment_scan_decoder;

   logic        clk_in;
   logic        reset;
   logic        sample_en;
   logic [3:0]  dig_sel;
   logic [6:0]  seg_in;
   logic [15:0] hex_out;
   logic [3:0]  valid;
   logic [3:0]  pattern_err;
   logic        update;
   logic [1:0]  upd_digit;
   logic        sel_err;

   int n_checks = 0;
   int n_fail   = 0;

   seven_segment_scan_decoder dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .sample_en   (sample_en),
      .dig_sel     (dig_sel),
      .seg_in      (seg_in),
      .hex_out     (hex_out),
      .valid       (valid),
      .pattern_err (pattern_err),
      .update      (update),
      .upd_digit   (upd_digit),
      .sel_err     (sel_err)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic tick(input logic [3:0] sel, input logic [6:0] seg);
      sample_en = 1'b1;
      dig_sel   = sel;
      seg_in    = seg;
      @(posedge clk_in);
      #1;
      sample_en = 1'b0;
      dig_sel   = 4'b0000;
      seg_in    = 7'h00;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk_in);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      // Reset must win over a concurrent multi-hot sample.
      reset = 1'b1; sample_en = 1'b1; dig_sel = 4'b0110; seg_in = 7'h5B;
      repeat (3) @(posedge clk_in);
      #1;
      n_checks++; if (hex_out !== 16'h0000) begin n_fail++; $display("FAIL reset_hex got=%h exp=0000", hex_out); end
      n_checks++; if (valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got=%b exp=0000", valid); end
      n_checks++; if (pattern_err !== 4'b0000) begin n_fail++; $display("FAIL reset_perr got=%b exp=0000", pattern_err); end
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update got=%b exp=0", update); end
      n_checks++; if (upd_digit !== 2'd0) begin n_fail++; $display("FAIL reset_upd_digit got=%0d exp=0", upd_digit); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
      reset = 1'b0; sample_en = 1'b0; dig_sel = 4'b0000; seg_in = 7'h00;
   endtask

   task automatic test_stable_commit();
      tick(4'b0001, 7'h5B);
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL stable_t1_update got=%b exp=0", update); end
      tick(4'b0001, 7'h5B);
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL stable_t2_update got=%b exp=0", update); end
      tick(4'b0001, 7'h5B);
      n_checks++; if (update !== 1'b1) begin n_fail++; $display("FAIL stable_t3_update got=%b exp=1", update); end
      n_checks++; if (upd_digit !== 2'd0) begin n_fail++; $display("FAIL stable_upd_digit got=%0d exp=0", upd_digit); end
      n_checks++; if (hex_out[3:0] !== 4'h2) begin n_fail++; $display("FAIL stable_hex got=%h exp=2", hex_out[3:0]); end
      n_checks++; if (valid !== 4'b0001) begin n_fail++; $display("FAIL stable_valid got=%b exp=0001", valid); end
      tick(4'b0001, 7'h5B);
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL stable_t4_no_recommit got=%b exp=0", update); end
   endtask

   task automatic test_glitch();
      logic [6:0] pats [5] = '{7'h06, 7'h06, 7'h4F, 7'h4F, 7'h4F};
      int ups = 0;
      for (int i = 0; i < 5; i++) begin
         tick(4'b0010, pats[i]);
         if (update) ups++;
         if (i < 4) begin
            n_checks++; if (hex_out[7:4] !== 4'h0) begin n_fail++; $display("FAIL glitch_hold_%0d got=%h exp=0", i, hex_out[7:4]); end
         end
      end
      n_checks++; if (ups !== 1) begin n_fail++; $display("FAIL glitch_update_count got=%0d exp=1", ups); end
      n_checks++; if (hex_out[7:4] !== 4'h3) begin n_fail++; $display("FAIL glitch_hex got=%h exp=3", hex_out[7:4]); end
      n_checks++; if (valid !== 4'b0011) begin n_fail++; $display("FAIL glitch_valid got=%b exp=0011", valid); end
   endtask

   task automatic test_illegal();
      repeat (3) tick(4'b0100, 7'h77);
      n_checks++; if (hex_out[11:8] !== 4'hA) begin n_fail++; $display("FAIL illegal_pre_hex got=%h exp=A", hex_out[11:8]); end
      n_checks++; if (valid !== 4'b0111) begin n_fail++; $display("FAIL illegal_pre_valid got=%b exp=0111", valid); end
      repeat (3) tick(4'b0100, 7'h12);
      n_checks++; if (update !== 1'b1 || upd_digit !== 2'd2) begin n_fail++; $display("FAIL illegal_update got=%b/%0d exp=1/2", update, upd_digit); end
      n_checks++; if (pattern_err !== 4'b0100) begin n_fail++; $display("FAIL illegal_perr got=%b exp=0100", pattern_err); end
      n_checks++; if (valid !== 4'b0011) begin n_fail++; $display("FAIL illegal_valid got=%b exp=0011", valid); end
      n_checks++; if (hex_out[11:8] !== 4'hA) begin n_fail++; $display("FAIL illegal_hex_held got=%h exp=A", hex_out[11:8]); end
   endtask

   task automatic test_sel_err();
      tick(4'b0000, 7'h3F);
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_zero_err got=%b exp=0", sel_err); end
      tick(4'b0110, 7'h3F);
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_multi_err got=%b exp=1", sel_err); end
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL sel_multi_update got=%b exp=0", update); end
      n_checks++; if (hex_out !== 16'h0A32) begin n_fail++; $display("FAIL sel_multi_hex got=%h exp=0a32", hex_out); end
      n_checks++; if (valid !== 4'b0011 || pattern_err !== 4'b0100) begin n_fail++; $display("FAIL sel_multi_flags got=%b/%b exp=0011/0100", valid, pattern_err); end
      tick(4'b0000, 7'h06);
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_sticky got=%b exp=1", sel_err); end
   endtask

   task automatic test_reset_mid_run();
      tick(4'b1000, 7'h7F);
      tick(4'b1000, 7'h7F);
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_update got=%b exp=0", update); end
      pulse_reset();
      n_checks++; if (hex_out !== 16'h0000 || sel_err !== 1'b0 || pattern_err !== 4'b0000) begin n_fail++; $display("FAIL midrst_cleared got=%h/%b/%b exp=0000/0/0000", hex_out, sel_err, pattern_err); end
      tick(4'b1000, 7'h7F);
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL midrst_first_update got=%b exp=0", update); end
      tick(4'b1000, 7'h7F);
      n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL midrst_second_update got=%b exp=0", update); end
      tick(4'b1000, 7'h7F);
      n_checks++; if (update !== 1'b1 || upd_digit !== 2'd3) begin n_fail++; $display("FAIL midrst_commit got=%b/%0d exp=1/3", update, upd_digit); end
      n_checks++; if (hex_out[15:12] !== 4'h8) begin n_fail++; $display("FAIL midrst_hex got=%h exp=8", hex_out[15:12]); end
   endtask

   task automatic test_blank();
      // Digit 0 still holds last_pat 00 from the reset, so three blanks commit.
      repeat (3) tick(4'b0001, 7'h00);
      n_checks++; if (update !== 1'b1 || upd_digit !== 2'd0) begin n_fail++; $display("FAIL blank_reset_commit got=%b/%0d exp=1/0", update, upd_digit); end
      n_checks++; if (valid !== 4'b1000 || pattern_err !== 4'b0000) begin n_fail++; $display("FAIL blank_reset_flags got=%b/%b exp=1000/0000", valid, pattern_err); end
      repeat (3) tick(4'b1000, 7'h00);
      n_checks++; if (valid !== 4'b0000 || pattern_err !== 4'b0000) begin n_fail++; $display("FAIL blank_digit3_flags got=%b/%b exp=0000/0000", valid, pattern_err); end
      n_checks++; if (hex_out[15:12] !== 4'h8) begin n_fail++; $display("FAIL blank_hex_held got=%h exp=8", hex_out[15:12]); end
   endtask

   task automatic test_back_to_back();
      logic [6:0] pats [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
      int ups = 0;
      pulse_reset();
      for (int i = 0; i < 12; i++) begin
         tick(4'b0001 << (i % 4), pats[i % 4]);
         if (update) begin
            ups++;
            n_checks++; if (upd_digit !== 2'(i % 4)) begin n_fail++; $display("FAIL rr_upd_digit tick=%0d got=%0d exp=%0d", i, upd_digit, i % 4); end
         end
      end
      n_checks++; if (ups !== 4) begin n_fail++; $display("FAIL rr_update_count got=%0d exp=4", ups); end
      n_checks++; if (hex_out !== 16'h3210) begin n_fail++; $display("FAIL rr_hex got=%h exp=3210", hex_out); end
      n_checks++; if (valid !== 4'b1111) begin n_fail++; $display("FAIL rr_valid got=%b exp=1111", valid); end
   endtask

   initial begin
      reset = 1'b1; sample_en = 1'b0; dig_sel = 4'b0000; seg_in = 7'h00;
      test_reset();
      test_stable_commit();
      test_glitch();
      test_illegal();
      test_sel_err();
      test_reset_mid_run();
      test_blank();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
